// File: rtl/mm_stream_tx.sv
// ---------------------------------------------------------------------------
// mm_stream_tx
//   Transmitter side of the matrix-multiplier input stream. Holds two signed
//   8-bit operand matrices A and B (up to 4x4, row-major) loaded through a
//   simple write port. On start it streams A, a fixed idle gap, then B, one
//   element per cycle. It then follows the multiplier's busy handshake
//   (rise, then fall) and reports done. If busy never rises it aborts with
//   tout.
//
// Parameters
//   GAP      idle cycles between A's last element and B's first (1..7)
//   TIMEOUT  max WAIT_HI cycles before giving up on mm_busy rising
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wr_en/i_wr_sel/i_wr_addr/i_wr_data
//                                element write (IDLE only); sel 0=A, 1=B
//   i_a_rows/i_a_cols/i_b_rows/i_b_cols
//                                dimensions, sampled on an accepted start
//   i_start                      one-cycle transmit request (IDLE only)
//   i_mm_busy                    busy from the multiplier
//   o_in_data                    streamed element (0 outside SEND_A/SEND_B)
//   o_col_end                    last element of a row
//   o_row_end                    last element of the matrix
//   o_ready                      high in IDLE
//   o_done                       one-cycle pulse at end of transaction
//   o_err                        one-cycle pulse, illegal dims, nothing sent
//   o_tout                       pulse with o_done when busy never rose
//   o_dbg_state                  current FSM state, for observation
//
// Handshake: i_start is a single-cycle request honoured only while o_ready is
// high; it is never queued. The stream itself has no back-pressure: every
// cycle of SEND_A/SEND_B carries a valid element, and i_mm_busy is only
// looked at in WAIT_HI/WAIT_LO.
// ---------------------------------------------------------------------------
module mm_stream_tx #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic       i_wr_sel,
  input  logic [3:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic [2:0] i_a_rows,
  input  logic [2:0] i_a_cols,
  input  logic [2:0] i_b_rows,
  input  logic [2:0] i_b_cols,
  input  logic       i_start,
  input  logic       i_mm_busy,
  output logic [7:0] o_in_data,
  output logic       o_col_end,
  output logic       o_row_end,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_err,
  output logic       o_tout,
  output logic [2:0] o_dbg_state
);

  // Shared counter for the gap and the busy-rise timeout; wide enough for
  // TIMEOUT and for GAP (<= 7).
  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERR     = 3'd1,
    S_SEND_A  = 3'd2,
    S_GAP     = 3'd3,
    S_SEND_B  = 3'd4,
    S_WAIT_HI = 3'd5,
    S_WAIT_LO = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Operand storage; deliberately not reset so operands survive a reset.
  logic [7:0] r_mem_a [16];
  logic [7:0] r_mem_b [16];

  state_t        r_state;
  logic [2:0]    r_a_rows;
  logic [2:0]    r_a_cols;
  logic [2:0]    r_b_rows;
  logic [2:0]    r_b_cols;
  // Position of the element currently on the output.
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [CW-1:0] r_cnt;

  function automatic logic dim_bad(input logic [2:0] d);
    return (d == 3'd0) || (d > 3'd4);
  endfunction

  // Row-major index r*cols + c; with legal dims the maximum is 15.
  function automatic logic [3:0] elem_idx(input logic [1:0] r,
                                          input logic [2:0] cols,
                                          input logic [1:0] c);
    return ({2'b00, r} * {1'b0, cols}) + {2'b00, c};
  endfunction

  logic       w_dims_bad;
  logic [2:0] w_rows;
  logic [2:0] w_cols;
  logic       w_last_col;
  logic       w_last_elem;
  logic [1:0] w_nxt_row;
  logic [1:0] w_nxt_col;
  logic [3:0] w_nxt_idx;
  logic       w_nxt_col_end;
  logic       w_nxt_row_end;
  logic [7:0] w_nxt_data;
  logic [7:0] w_a0_data;
  logic       w_a0_col_end;
  logic       w_a0_row_end;
  logic       w_b0_col_end;
  logic       w_b0_row_end;

  assign w_dims_bad = dim_bad(i_a_rows) | dim_bad(i_a_cols) |
                      dim_bad(i_b_rows) | dim_bad(i_b_cols);

  // Sequencing for whichever matrix is being streamed now.
  always_comb begin
    w_rows        = (r_state == S_SEND_B) ? r_b_rows : r_a_rows;
    w_cols        = (r_state == S_SEND_B) ? r_b_cols : r_a_cols;
    w_last_col    = ({1'b0, r_col} == (w_cols - 3'd1));
    w_last_elem   = w_last_col && ({1'b0, r_row} == (w_rows - 3'd1));
    w_nxt_row     = w_last_col ? (r_row + 2'd1) : r_row;
    w_nxt_col     = w_last_col ? 2'd0 : (r_col + 2'd1);
    w_nxt_idx     = elem_idx(w_nxt_row, w_cols, w_nxt_col);
    w_nxt_col_end = ({1'b0, w_nxt_col} == (w_cols - 3'd1));
    w_nxt_row_end = w_nxt_col_end && ({1'b0, w_nxt_row} == (w_rows - 3'd1));
    w_nxt_data    = (r_state == S_SEND_B) ? r_mem_b[w_nxt_idx]
                                          : r_mem_a[w_nxt_idx];
  end

  // A[0] is registered on the same edge that accepts start. A write to A[0]
  // in that very cycle must be seen, so forward it around the memory.
  assign w_a0_data    = (i_wr_en && !i_wr_sel && (i_wr_addr == 4'd0))
                        ? i_wr_data : r_mem_a[0];
  assign w_a0_col_end = (i_a_cols == 3'd1);
  assign w_a0_row_end = (i_a_cols == 3'd1) && (i_a_rows == 3'd1);
  assign w_b0_col_end = (r_b_cols == 3'd1);
  assign w_b0_row_end = (r_b_cols == 3'd1) && (r_b_rows == 3'd1);

  assign o_dbg_state = r_state;

  // Operand writes, accepted only while idle.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && (r_state == S_IDLE)) begin
      if (i_wr_sel) begin
        r_mem_b[i_wr_addr] <= i_wr_data;
      end else begin
        r_mem_a[i_wr_addr] <= i_wr_data;
      end
    end
  end

  // Main FSM. Outputs are registered alongside the state, so each output
  // value belongs to the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_a_rows  <= 3'd0;
      r_a_cols  <= 3'd0;
      r_b_rows  <= 3'd0;
      r_b_cols  <= 3'd0;
      r_row     <= 2'd0;
      r_col     <= 2'd0;
      r_cnt     <= '0;
      o_in_data <= 8'd0;
      o_col_end <= 1'b0;
      o_row_end <= 1'b0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_tout    <= 1'b0;
    end else begin
      o_in_data <= 8'd0;
      o_col_end <= 1'b0;
      o_row_end <= 1'b0;
      o_ready   <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_tout    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          o_ready <= 1'b1;
          if (i_start) begin
            o_ready <= 1'b0;
            if (w_dims_bad) begin
              r_state <= S_ERR;
              o_err   <= 1'b1;
            end else begin
              r_state   <= S_SEND_A;
              r_a_rows  <= i_a_rows;
              r_a_cols  <= i_a_cols;
              r_b_rows  <= i_b_rows;
              r_b_cols  <= i_b_cols;
              r_row     <= 2'd0;
              r_col     <= 2'd0;
              o_in_data <= w_a0_data;
              o_col_end <= w_a0_col_end;
              o_row_end <= w_a0_row_end;
            end
          end
        end

        S_ERR: begin
          r_state <= S_IDLE;
          o_ready <= 1'b1;
        end

        S_SEND_A: begin
          if (w_last_elem) begin
            r_state <= S_GAP;
            r_cnt   <= CW'(1);
          end else begin
            r_row     <= w_nxt_row;
            r_col     <= w_nxt_col;
            o_in_data <= w_nxt_data;
            o_col_end <= w_nxt_col_end;
            o_row_end <= w_nxt_row_end;
          end
        end

        // r_cnt numbers the gap cycle being shown (1..GAP).
        S_GAP: begin
          if (r_cnt == CW'(GAP)) begin
            r_state   <= S_SEND_B;
            r_row     <= 2'd0;
            r_col     <= 2'd0;
            o_in_data <= r_mem_b[0];
            o_col_end <= w_b0_col_end;
            o_row_end <= w_b0_row_end;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_SEND_B: begin
          if (w_last_elem) begin
            r_state <= S_WAIT_HI;
            r_cnt   <= CW'(1);
          end else begin
            r_row     <= w_nxt_row;
            r_col     <= w_nxt_col;
            o_in_data <= w_nxt_data;
            o_col_end <= w_nxt_col_end;
            o_row_end <= w_nxt_row_end;
          end
        end

        // Busy seen in the last allowed cycle still counts as a rise.
        S_WAIT_HI: begin
          if (i_mm_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_cnt == CW'(TIMEOUT)) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
            o_tout  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_LO: begin
          if (!i_mm_busy) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          o_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_mm_stream_tx
//   Self-checking bench for mm_stream_tx. A behavioural model holds copies of
//   both operand memories and, for each transaction, builds the expected
//   per-cycle stream (A row by row, GAP zero cycles, B row by row) into a
//   queue. The done/tout cycle is derived from the busy pattern driven.
// ---------------------------------------------------------------------------
module tb_mm_stream_tx;

  localparam int GAP_P = 2;
  localparam int TO_P  = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en;
  logic       wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] a_rows, a_cols, b_rows, b_cols;
  logic       start;
  logic       mm_busy;
  logic [7:0] in_data;
  logic       col_end, row_end, ready, done, err, tout;
  logic [2:0] dbg_state;

  mm_stream_tx #(.GAP(GAP_P), .TIMEOUT(TO_P)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (wr_en),
    .i_wr_sel    (wr_sel),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_a_rows    (a_rows),
    .i_a_cols    (a_cols),
    .i_b_rows    (b_rows),
    .i_b_cols    (b_cols),
    .i_start     (start),
    .i_mm_busy   (mm_busy),
    .o_in_data   (in_data),
    .o_col_end   (col_end),
    .o_row_end   (row_end),
    .o_ready     (ready),
    .o_done      (done),
    .o_err       (err),
    .o_tout      (tout),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  // Expected stream entries: {col_end, row_end, data}
  logic [9:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outv();
    return {18'd0, ready, done, err, tout, col_end, row_end, in_data};
  endfunction

  function automatic logic [31:0] ev(input bit rdy, input bit dn,
                                     input bit er, input bit to,
                                     input bit ce, input bit re,
                                     input logic [7:0] d);
    return {18'd0, rdy, dn, er, to, ce, re, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_elem(input bit sel, input int addr, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) mem_b[addr] = d;
    else     mem_a[addr] = d;
  endtask

  // Expected stream for the given dims from the model memories.
  task automatic build_stream(input int ar, input int ac, input int br,
                              input int bc);
    exp_q.delete();
    for (int r = 0; r < ar; r++)
      for (int c = 0; c < ac; c++)
        exp_q.push_back({(c == ac - 1), (r == ar - 1 && c == ac - 1),
                         mem_a[r * ac + c]});
    for (int g = 0; g < GAP_P; g++) exp_q.push_back(10'd0);
    for (int r = 0; r < br; r++)
      for (int c = 0; c < bc; c++)
        exp_q.push_back({(c == bc - 1), (r == br - 1 && c == bc - 1),
                         mem_b[r * bc + c]});
  endtask

  // One transaction. busy stays low for d WAIT cycles, then high for h.
  // disturb: pulse start/wr_en throughout SEND_A. rst_at: stream index at
  // which reset is asserted (-1 for none).
  task automatic run_txn(input int ar, input int ac, input int br,
                         input int bc, input int d, input int h,
                         input bit disturb, input int rst_at);
    int n;
    int done_k;
    bit te;
    build_stream(ar, ac, br, bc);
    n = exp_q.size();
    a_rows = 3'(ar); a_cols = 3'(ac); b_rows = 3'(br); b_cols = 3'(bc);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("stream[%0d]", i), outv(),
            ev(0, 0, 0, 0, exp_q[i][9], exp_q[i][8], exp_q[i][7:0]));
      if (i == rst_at) begin
        rst = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        mm_busy = 1'b0;
        tick();
        check("rst_mid", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));
        rst = 1'b0;
        tick();
        check("rst_idle", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));
        return;
      end
      // Busy glitches while streaming must be ignored.
      mm_busy = 1'($urandom_range(0, 1));
      if (disturb && i < ar * ac) begin
        start   = 1'($urandom_range(0, 1));
        wr_en   = 1'b1;
        wr_sel  = 1'($urandom_range(0, 1));
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = 8'($urandom);
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    wr_en = 1'b0;
    if (d < TO_P) begin
      done_k = d + h + 1;
      te = 1'b0;
    end else begin
      done_k = TO_P;
      te = 1'b1;
    end
    for (int k = 0; k < done_k; k++) begin
      check($sformatf("wait[%0d]", k), outv(), ev(0, 0, 0, 0, 0, 0, 8'd0));
      mm_busy = (k >= d) && (k < d + h);
      tick();
    end
    check("done", outv(), ev(0, 1, 0, te, 0, 0, 8'd0));
    mm_busy = 1'b0;
    tick();
    check("idle_after", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));
  endtask

  task automatic run_err(input int ar, input int ac, input int br,
                         input int bc);
    a_rows = 3'(ar); a_cols = 3'(ac); b_rows = 3'(br); b_cols = 3'(bc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", outv(), ev(0, 0, 1, 0, 0, 0, 8'd0));
    tick();
    check("err_idle", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    a_rows = 3'd0; a_cols = 3'd0; b_rows = 3'd0; b_cols = 3'd0;
    start = 1'b0; mm_busy = 1'b0;
    tick();
    tick();
    check("reset", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));
    rst = 1'b0;
    tick();
    check("reset_idle", outv(), ev(1, 0, 0, 0, 0, 0, 8'd0));

    for (int i = 0; i < 16; i++) begin
      write_elem(1'b0, i, 8'($urandom));
      write_elem(1'b1, i, 8'($urandom));
    end

    // Basic 2x2 * 2x2
    for (int i = 0; i < 4; i++) begin
      write_elem(1'b0, i, 8'(i + 1));
      write_elem(1'b1, i, 8'(i + 5));
    end
    run_txn(2, 2, 2, 2, 0, 3, 1'b0, -1);

    // Signed extremes, 1x4 and 4x1
    write_elem(1'b0, 0, 8'hFF);
    write_elem(1'b0, 1, 8'h7F);
    write_elem(1'b0, 2, 8'h80);
    write_elem(1'b0, 3, 8'h00);
    for (int i = 0; i < 4; i++) write_elem(1'b1, i, 8'd2);
    run_txn(1, 4, 4, 1, 2, 1, 1'b0, -1);

    // Illegal dims, then a legal start
    run_err(0, 2, 2, 2);
    run_err(2, 2, 2, 5);
    run_txn(2, 2, 2, 2, 1, 2, 1'b0, -1);

    // Busy never rises
    run_txn(2, 3, 3, 2, 1000, 1, 1'b0, -1);

    // Disturbances during SEND_A, then replay to confirm memory intact
    run_txn(4, 4, 4, 4, 0, 1, 1'b1, -1);
    run_txn(4, 4, 4, 4, 3, 2, 1'b0, -1);

    // Reset on the second B element, then replay without reloading
    run_txn(2, 2, 2, 2, 0, 1, 1'b0, 4 + GAP_P + 1);
    run_txn(2, 2, 2, 2, 0, 1, 1'b0, -1);

    // Write to A[0] in the same cycle as start
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h5A;
    mem_a[0] = 8'h5A;
    run_txn(3, 3, 3, 1, 0, 2, 1'b0, -1);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      int n_wr;
      n_wr = $urandom_range(0, 4);
      for (int w = 0; w < n_wr; w++)
        write_elem(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                   8'($urandom));
      run_txn($urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(0, 8), $urandom_range(1, 5),
              1'($urandom_range(0, 1)), -1);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_stream_tx.md
Name: mm_stream_tx

Overview:
- Transmitter side of the matrix-multiplier input stream.
- Holds operand matrices A and B, each up to 4x4, signed 8-bit, row-major, loaded through a write port.
- On start, serializes A then B as one element per cycle on in_data, marking row and matrix boundaries with col_end/row_end.
- Then tracks the multiplier's busy handshake until the result phase completes and reports done.

Parameters:
- GAP, 2: idle cycles inserted between the last element of A and the first element of B (range 1..7).
- TIMEOUT, 64: max cycles to wait for mm_busy to rise after B's last element before aborting with tout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write one operand element (honoured only in IDLE)
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_addr  in  4  row-major element index r*cols+c
- wr_data  in  8  element value
- a_rows, a_cols, b_rows, b_cols  in  3 each  dimensions, sampled on accepted start
- start  in  1  one-cycle request to transmit
- mm_busy  in  1  busy from the multiplier
- in_data  out  8  stream element
- col_end  out  1  last element of a row
- row_end  out  1  last element of the matrix
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse at end of transaction
- err  out  1  one-cycle pulse: illegal dimensions, nothing sent
- tout  out  1  one-cycle pulse, coincident with done: busy handshake timed out

Behaviour:
- Reset:
  - in_data=0, col_end=0, row_end=0, done=0, err=0, tout=0, ready=1, state IDLE.
  - Latched dims and counters are cleared.
  - Element memories are not reset and keep their contents.
- All outputs are registered.
- States and transitions:
  - IDLE: ready=1; wr_en writes mem[wr_sel][wr_addr].
    - start accepted when in IDLE; same-cycle wr_en and start: write completes, start also accepted.
    - Any dim equal to 0 or greater than 4 -> ERR.
    - Otherwise latch dims -> SEND_A.
  - ERR: err=1 for one cycle -> IDLE. Legal dims with a_cols != b_rows are NOT an error; the multiplier judges legality.
  - SEND_A: one element per cycle, r outer, c inner.
    - First element appears the cycle after start is accepted.
    - col_end=1 when c==a_cols-1.
    - row_end=1 additionally on the final element (r==a_rows-1, c==a_cols-1).
    - After a_rows*a_cols cycles -> GAP.
  - GAP: GAP cycles with in_data=0, col_end=0, row_end=0 -> SEND_B.
  - SEND_B: same sequencing over B with b_rows/b_cols -> WAIT_HI.
  - WAIT_HI: waits for mm_busy=1 -> WAIT_LO.
    - Cycle counter starts at 1 on entry.
    - If the counter reaches TIMEOUT without mm_busy -> DONE with tout.
  - WAIT_LO: waits for mm_busy=0 -> DONE. No timeout here.
  - DONE: done=1 for one cycle (tout=1 too if flagged) -> IDLE.
- Outside SEND_A/SEND_B: in_data, col_end and row_end are 0.
- Addressing:
  - index = r*cols + c (4-bit, max 15).
  - Element emitted unmodified (raw two's-complement byte).
- ready=0 in every state except IDLE.
- start outside IDLE is ignored, not queued.
- wr_en outside IDLE is ignored; memory is unchanged.
- mm_busy already high on WAIT_HI entry: immediate transition to WAIT_LO next cycle.
- mm_busy glitching high during SEND_A/SEND_B/GAP: ignored; streaming is never stalled.
- rst asserted mid-stream: next edge forces reset values; any partial stream is abandoned with no done pulse.
- Transaction latency, no timeout: 1 + a_rows*a_cols + GAP + b_rows*b_cols + WAIT_HI/WAIT_LO cycles + 1 (DONE).

Test Plan:
- Load A=[[1,2],[3,4]], B=[[5,6],[7,8]], dims 2/2/2/2, GAP=2, start.
  - Expect in_data 1,2,3,4, then 0,0, then 5,6,7,8.
  - col_end on cycles 2,4 of each matrix; row_end only on 4 and 8.
  - Model busy high 3 cycles after B -> done 1 cycle after busy falls.
- 1x4 A=[-1,127,-128,0], 4x1 B=[2,2,2,2]: bytes FF,7F,80,00.
  - col_end and row_end both only on the 4th A element.
  - Every B element has col_end=1; the last also has row_end.
- a_rows=0 or b_cols=5 with start: err pulse next cycle, no stream, ready back high; a following legal start streams normally.
- mm_busy held 0 after B: tout and done pulse together after TIMEOUT=64 cycles in WAIT_HI.
- start and wr_en pulsed during SEND_A: stream unchanged, memory unchanged (verified by re-streaming).
- rst asserted during SEND_B on element 2: outputs 0 and ready=1 next cycle, no done. Restart without reloading replays the original data.
